// File: rtl/hilo_controller.sv
// HI/LO register controller for the MIPS-style multiply/divide units.
// Sequences unit start pulses, result capture and mthi/mtlo writes.
module hilo_controller #(
    parameter int DIV_LATENCY  = 36,
    parameter int MULT_LATENCY = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic        mult_start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wr_data,
    output logic        div_op,
    output logic        mult_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        div_by_zero,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] DIV_ISSUE  = 3'd1;
    localparam logic [2:0] DIV_CHECK  = 3'd2;
    localparam logic [2:0] DIV_WAIT   = 3'd3;
    localparam logic [2:0] MULT_ISSUE = 3'd4;
    localparam logic [2:0] MULT_WAIT  = 3'd5;
    localparam logic [2:0] WRITE      = 3'd6;

    // cnt reads k-1 during cycle k after the issue cycle
    localparam logic [5:0] DIV_LAST  = 6'(DIV_LATENCY - 1);
    localparam logic [5:0] MULT_LAST = 6'(MULT_LATENCY - 1);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [5:0] cnt;
    logic       idle;
    logic       div_cap;
    logic       mult_cap;

    assign idle     = (state == IDLE);
    assign div_cap  = (state == DIV_WAIT) && (cnt == DIV_LAST);
    assign mult_cap = (state == MULT_WAIT) && (cnt == MULT_LAST);

    assign busy    = !idle;
    assign div_op  = (state == DIV_ISSUE);
    assign mult_op = (state == MULT_ISSUE);
    assign done    = (state == WRITE);

    // Next-state decode; divide wins over a simultaneous multiply
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (div_start)
                    state_nx = DIV_ISSUE;
                else if (mult_start)
                    state_nx = MULT_ISSUE;
            end
            DIV_ISSUE:  state_nx = DIV_CHECK;
            DIV_CHECK:  state_nx = div_by_zero ? IDLE : DIV_WAIT;
            DIV_WAIT:   state_nx = div_cap ? WRITE : DIV_WAIT;
            MULT_ISSUE: state_nx = MULT_WAIT;
            MULT_WAIT:  state_nx = mult_cap ? WRITE : MULT_WAIT;
            WRITE:      state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Latency counter: cleared on issue, counts while an op is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (div_op || mult_op)
            cnt <= '0;
        else if (!idle)
            cnt <= cnt + 6'd1;
    end

    // Operand latch, HI/LO writes and captures, divide-by-zero pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unit_a       <= '0;
            unit_b       <= '0;
            hi           <= '0;
            lo           <= '0;
            div_zero_exc <= 1'b0;
        end else begin
            div_zero_exc <= (state == DIV_CHECK) && div_by_zero;
            if (idle) begin
                if (hi_we)
                    hi <= wr_data;
                if (lo_we)
                    lo <= wr_data;
                if (div_start || mult_start) begin
                    unit_a <= op_a;
                    unit_b <= op_b;
                end
            end
            if (div_cap) begin
                hi <= div_remainder;
                lo <= div_quotient;
            end
            if (mult_cap) begin
                hi <= mult_hi;
                lo <= mult_lo;
            end
        end
    end

endmodule
